// File: rtl/ui_cond_pkg.sv
// Shared defaults and the debounce counter width derivation for the
// ui_in conditioning stage.
package ui_cond_pkg;
    localparam int UI_WIDTH       = 8;
    localparam int UI_SYNC_STAGES = 2;
    localparam int UI_DB_CYCLES   = 16;

    // Counter only needs to reach DB_CYCLES-1, but sizing for DB_CYCLES+1
    // values keeps DB_CYCLES=1 at a legal 1-bit width.
    function automatic int cnt_w(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction
endpackage

// File: rtl/ui_debounce_bit.sv
// One conditioned input bit: metastability synchroniser, debounce counter
// and registered rise/fall pulses aligned with the level change.
module ui_debounce_bit
    import ui_cond_pkg::*;
#(
    parameter int SYNC_STAGES = UI_SYNC_STAGES,
    parameter int DB_CYCLES   = UI_DB_CYCLES,
    parameter int CNT_W       = cnt_w(UI_DB_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ena,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_flip
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic             w_s;
    logic             w_diff;
    logic             w_at_max;
    logic             w_flip;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_s ^ r_level;
    assign w_at_max = (r_cnt == CNT_W'(DB_CYCLES - 1));
    assign w_flip   = i_ena & w_diff & w_at_max;

    // Counter restarts on agreement, on a flip, and whenever disabled.
    always_comb begin
        w_cnt_nxt = '0;
        if (i_ena && w_diff && !w_at_max)
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_cnt   <= w_cnt_nxt;
            r_level <= r_level ^ w_flip;
            r_rise  <= w_flip & ~r_level;
            r_fall  <= w_flip &  r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_flip  = w_flip;
endmodule

// File: rtl/ui_in_conditioner.sv
// Conditions the raw ui_in bits into debounced levels plus per-bit edge
// pulses and a combined any-change pulse.
module ui_in_conditioner
    import ui_cond_pkg::*;
#(
    parameter int WIDTH       = UI_WIDTH,
    parameter int SYNC_STAGES = UI_SYNC_STAGES,
    parameter int DB_CYCLES   = UI_DB_CYCLES,
    parameter int CNT_W       = cnt_w(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             any_change
);
    logic [WIDTH-1:0] w_flip;
    logic             r_any;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ui_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_bit (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_ena  (ena),
            .i_raw  (raw_in[gi]),
            .o_level(level_out[gi]),
            .o_rise (rise_out[gi]),
            .o_fall (fall_out[gi]),
            .o_flip (w_flip[gi])
        );
    end

    // Registered from the pre-edge flips so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) r_any <= 1'b0;
        else     r_any <= |w_flip;
    end

    assign any_change = r_any;
endmodule

// File: tb/tb_ui_in_conditioner.sv
// Directed bench for ui_in_conditioner at SYNC_STAGES=2, DB_CYCLES=4.
module tb_ui_in_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] raw_in;
    logic [7:0] level_out;
    logic [7:0] rise_out;
    logic [7:0] fall_out;
    logic       any_change;

    int checks = 0;
    int errors = 0;

    ui_in_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] rs,
                           input logic [7:0] fl, input logic an);
        chk({tag, ".level"}, level_out, lvl);
        chk({tag, ".rise"}, rise_out, rs);
        chk({tag, ".fall"}, fall_out, fl);
        chk({tag, ".any"}, {7'b0, any_change}, {7'b0, an});
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; raw_in = 8'hFF;
        tick(3);
        chk_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);

        // Release with all inputs high: qualify 6 edges later.
        rst = 1'b0;
        tick(5);
        chk_all("rel_t5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("rel_t6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        tick(1);
        chk_all("rel_t7", 8'hFF, 8'h00, 8'h00, 1'b0);

        // Back to all-zero via reset for the single-bit tests.
        rst = 1'b1; raw_in = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(2);
        chk_all("clean", 8'h00, 8'h00, 8'h00, 1'b0);

        // Bit 3 rise then fall.
        raw_in = 8'h08;
        tick(5);
        chk_all("b3r_t5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("b3r_t6", 8'h08, 8'h08, 8'h00, 1'b1);
        tick(1);
        chk_all("b3r_t7", 8'h08, 8'h00, 8'h00, 1'b0);
        raw_in = 8'h00;
        tick(5);
        chk_all("b3f_t5", 8'h08, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("b3f_t6", 8'h00, 8'h00, 8'h08, 1'b1);
        tick(1);
        chk_all("b3f_t7", 8'h00, 8'h00, 8'h00, 1'b0);

        // 3-cycle glitch on bit 0 is filtered.
        raw_in = 8'h01;
        tick(3);
        raw_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk_all("glitch3", 8'h00, 8'h00, 8'h00, 1'b0);
            tick(1);
        end

        // 4-cycle pulse on bit 0 qualifies, then falls.
        raw_in = 8'h01;
        tick(4);
        raw_in = 8'h00;
        tick(1);
        chk_all("p4_t5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("p4_t6", 8'h01, 8'h01, 8'h00, 1'b1);
        tick(3);
        chk_all("p4_t9", 8'h01, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("p4_t10", 8'h00, 8'h00, 8'h01, 1'b1);
        tick(2);

        // Bit 1 high, ena dropped after edge 3 for 5 edges.
        raw_in = 8'h02;
        tick(3);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_all("ena_low", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        ena = 1'b1;
        tick(3);
        chk_all("ena_t3", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("ena_t4", 8'h02, 8'h02, 8'h00, 1'b1);
        tick(2);

        // Bits 7:4 flip together.
        raw_in = 8'hF2;
        tick(5);
        chk_all("multi_t5", 8'h02, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("multi_t6", 8'hF2, 8'hF0, 8'h00, 1'b1);
        tick(1);
        chk_all("multi_t7", 8'hF2, 8'h00, 8'h00, 1'b0);

        // Reset while bit 2 has counted to 2.
        raw_in = 8'hF6;
        tick(4);
        chk_all("mid_t4", 8'hF2, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick(1);
        chk_all("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk_all("mid_t5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        chk_all("mid_t6", 8'hF6, 8'hF6, 8'h00, 1'b1);
        tick(1);
        chk_all("mid_t7", 8'hF6, 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ui_in_conditioner.md
Name: ui_in_conditioner

Overview:
Input-conditioning stage directly upstream of the top-level user logic. It consumes the raw dedicated inputs (ui_in) and produces clean per-bit signals for the logic that drives uo_out:
- a synchronised, debounced level per bit;
- one-cycle rise and fall pulses per bit;
- an any-bit-changed pulse.

It lets the downstream combinational logic operate on bounce-free, clock-aligned inputs.

Parameters:
- WIDTH, 8, number of conditioned input bits (matches ui_in).
- SYNC_STAGES, 2, flops in each metastability synchroniser chain; legal range >= 2.
- DB_CYCLES, 16, consecutive cycles a synchronised bit must differ from its debounced level before that level flips; legal range >= 1.
- CNT_W, $clog2(DB_CYCLES+1), derived width of each debounce counter; not to be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset. The top wrapper derives it from rst_n.
- ena  input  1  design enable; low freezes debouncing.
- raw_in  input  WIDTH  asynchronous raw inputs (ui_in).
- level_out  output  WIDTH  debounced level per bit.
- rise_out  output  WIDTH  one-cycle pulse when level_out[i] goes 0->1.
- fall_out  output  WIDTH  one-cycle pulse when level_out[i] goes 1->0.
- any_change  output  1  one-cycle pulse, OR of rise_out|fall_out.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, sampled on the rising edge of clk. Every register clears on that edge when rst=1.
- Reset values:
  - sync chains all 0;
  - debounce counters 0;
  - level_out 0;
  - rise_out 0, fall_out 0, any_change 0.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops. The last stage is s[i]. The chain runs regardless of ena.
- Debounce, per bit, on each edge with rst=0 and ena=1:
  - if s[i]==level_out[i]: cnt[i]<=0;
  - else if cnt[i]==DB_CYCLES-1: level_out[i]<=~level_out[i], cnt[i]<=0;
  - else: cnt[i]<=cnt[i]+1.
- Pulses are registered in the same edge as the flip:
  - rise_out[i] <= flip & ~level_out[i];
  - fall_out[i] <= flip & level_out[i];
  - otherwise both are 0.
  - As a result, rise_out[i] and fall_out[i] are high exactly in the first cycle the new level is visible.
- any_change is registered from the OR of the next-state pulses. It is coincident with the pulses, not one cycle later.
- Latency: a clean step on raw_in[i] is first seen by the flop at edge 1. level_out[i] changes after edge SYNC_STAGES+DB_CYCLES, which is 18 cycles at the defaults.
- Glitch filtering: any excursion of s[i] lasting fewer than DB_CYCLES cycles resets cnt[i] on its return. level_out[i] does not change and no pulse is produced.
- Boundary case DB_CYCLES=1: the level flips on the first cycle s[i] differs.
- ena=0:
  - cnt cleared every cycle;
  - level_out held;
  - pulses forced to 0.
- When ena returns to 1, debouncing restarts from cnt=0. A pending difference therefore needs a full DB_CYCLES again.
- Bits are fully independent. Simultaneous flips on several bits give simultaneous pulses and a single-cycle any_change.
- Reset mid-count: level_out returns to 0 and the count is discarded. If raw_in is held at 1 through reset, the bit re-qualifies after SYNC_STAGES+DB_CYCLES cycles following the release of rst.
- Counter width: cnt never exceeds DB_CYCLES-1, so it does not wrap.

Decomposition:
- Shared package ui_cond_pkg holds:
  - the default constants UI_WIDTH=8, UI_SYNC_STAGES=2, UI_DB_CYCLES=16;
  - the clog2-based CNT_W derivation.
- One sub-module, ui_debounce_bit: a single-bit synchroniser plus counter plus edge pulses.
- The top instantiates WIDTH copies via generate and ORs their pulses into any_change.

Test Plan:
All scenarios use DB_CYCLES=4 and SYNC_STAGES=2.
- Reset with raw_in=8'hFF held -> all outputs 0 during rst. After release, level_out=8'hFF exactly 6 cycles later, rise_out=8'hFF for 1 cycle, and any_change=1 for 1 cycle.
- Step raw_in[3] 0->1 and hold -> level_out[3]=1 after edge 6 and rise_out[3]=1 for one cycle. No other bit changes. Then step 1->0 -> fall_out[3] pulses 6 cycles later.
- 3-cycle glitch on raw_in[0] (0->1->0) -> level_out, rise_out and any_change stay 0 throughout. A 4-cycle pulse on the same bit does produce rise_out[0], and the later fall back to 0 produces fall_out[0].
- Drive raw_in[1] high, drop ena at cycle 3 for 5 cycles, then restore -> no flip while ena=0. level_out[1] flips 4 cycles after ena returns.
- Flip raw_in[7:4] on the same cycle -> rise_out=8'hF0 in one cycle and a single one-cycle any_change.
- Assert rst mid-count (raw_in[2]=1, cnt=2) -> level_out[2]=0 and no pulse. After rst drops, level_out[2] rises after 6 cycles.
